// File: rtl/motorpasso_step_sequencer.sv
// Avalon-MM read master that plays a table of step words from on-chip RAM onto the coil outputs.
// Optional table looping is enabled by defining MOTORPASSO_STEP_LOOP_EN.
module motorpasso_step_sequencer #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int PER_W  = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [PER_W-1:0]  period,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [3:0]        coils,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   step_count
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, HOLD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [PER_W-1:0]    hold_q, hold_d;
  logic [3:0]          coils_q, coils_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dir_q, dir_d;
`ifdef MOTORPASSO_STEP_LOOP_EN
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    len_q, len_d;
`endif

  // Only the end-marker bit and the coil nibble of each step word carry meaning.
  logic unused_data;
  assign unused_data = ^mem_readdata[DATA_W-2:4];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    hold_d  = hold_q;
    coils_d = coils_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
`ifdef MOTORPASSO_STEP_LOOP_EN
    base_d  = base_q;
    len_d   = len_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          dir_d = dir;
          ptr_d = base_addr;
          rem_d = length;
          per_d = (period == '0) ? PER_W'(1) : period;
          cnt_d = '0;
`ifdef MOTORPASSO_STEP_LOOP_EN
          base_d = base_addr;
          len_d  = length;
`endif
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = FETCH;
            busy_d  = 1'b1;
          end
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        if (mem_readdata[DATA_W-1]) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          coils_d = mem_readdata[3:0];
`ifdef MOTORPASSO_STEP_LOOP_EN
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
`else
          cnt_d = cnt_q + CNT_W'(1);
`endif
          rem_d   = rem_q - CNT_W'(1);
          hold_d  = per_q - PER_W'(1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - PER_W'(1);
        end else if (rem_q != '0) begin
          ptr_d   = dir_q ? ptr_q + ADDR_W'(1) : ptr_q - ADDR_W'(1);
          state_d = FETCH;
        end else begin
`ifdef MOTORPASSO_STEP_LOOP_EN
          ptr_d   = base_q;
          rem_d   = len_q;
          state_d = FETCH;
`else
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a word being latched this cycle.
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      coils_d = coils_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      per_q   <= PER_W'(1);
      hold_q  <= '0;
      coils_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b1;
`ifdef MOTORPASSO_STEP_LOOP_EN
      base_q  <= '0;
      len_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      hold_q  <= hold_d;
      coils_q <= coils_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
`ifdef MOTORPASSO_STEP_LOOP_EN
      base_q  <= base_d;
      len_q   <= len_d;
`endif
    end
  end

  assign mem_address    = ptr_q;
  assign mem_chipselect = (state_q == FETCH);
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign coils          = coils_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign step_count     = cnt_q;

endmodule

// File: tb/tb_motorpasso_step_sequencer.sv
// Directed bench for motorpasso_step_sequencer with a behavioural one-cycle-latency RAM.
// Loop-mode checks are compiled when MOTORPASSO_STEP_LOOP_EN is defined.
module tb_motorpasso_step_sequencer;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int PER_W  = 24;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              stop;
  logic              dir;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic [PER_W-1:0]  period;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic [3:0]        coils;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   step_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  motorpasso_step_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PER_W(PER_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .dir(dir),
    .base_addr(base_addr), .length(length), .period(period),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .coils(coils), .busy(busy), .done(done), .step_count(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= ram[mem_address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge; returns 1 time unit after that edge (edge 0 of the run).
  task automatic start_run(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] len,
                           input logic d, input logic [PER_W-1:0] per);
    base_addr = b;
    length    = len;
    dir       = d;
    period    = per;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    base_addr = 13'h1FFF;
    length    = 14'd7;
    dir       = ~d;
    period    = 24'd9;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b1;
    base_addr = '0; length = '0; period = '0;
    ram[100] = 32'd1; ram[101] = 32'd2; ram[102] = 32'd4; ram[103] = 32'd8;
    ram[0] = 32'd5; ram[8191] = 32'd10;
    ram[10] = 32'd3; ram[11] = 32'h8000_0006;
    ram[20] = 32'd1; ram[21] = 32'd2;

    repeat (2) tick();
    chk("rst_coils", coils, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", step_count, 0);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_addr", mem_address, 0);
    chk("tie_write", mem_write, 0);
    chk("tie_be", mem_byteenable, 4'hF);
    chk("tie_clken", mem_clken, 1);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", busy, 0);
    chk("idle_cs", mem_chipselect, 0);

`ifndef MOTORPASSO_STEP_LOOP_EN
    $display("run: basic ascending base=100 len=4 period=3");
    start_run(13'd100, 14'd4, 1'b1, 24'd3);
    chk("basic_addr0", mem_address, 100);
    chk("basic_cs0", mem_chipselect, 1);
    chk("basic_busy0", busy, 1);
    for (int k = 1; k <= 22; k++) begin
      tick();
      case (k)
        1:  begin chk("basic_cs1", mem_chipselect, 0); chk("basic_coils1", coils, 0); end
        2:  chk("basic_coilsA", coils, 1);
        5:  begin chk("basic_addr5", mem_address, 101); chk("basic_cs5", mem_chipselect, 1); end
        6:  chk("basic_coils6", coils, 1);
        7:  chk("basic_coilsB", coils, 2);
        12: chk("basic_coilsC", coils, 4);
        17: chk("basic_coilsD", coils, 8);
        19: begin chk("basic_busy19", busy, 1); chk("basic_done19", done, 0); end
        20: begin chk("basic_done", done, 1); chk("basic_busy20", busy, 0);
                  chk("basic_cnt", step_count, 4); chk("basic_hold", coils, 8); end
        21: begin chk("basic_done21", done, 0); chk("basic_cs21", mem_chipselect, 0); end
        default: ;
      endcase
    end

    $display("run: descending wrap base=0 len=2 period=0");
    start_run(13'd0, 14'd2, 1'b0, 24'd0);
    chk("wrap_addr0", mem_address, 0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      case (k)
        2: chk("wrap_coilsA", coils, 5);
        3: begin chk("wrap_addr3", mem_address, 8191); chk("wrap_cs3", mem_chipselect, 1); end
        4: chk("wrap_coils4", coils, 5);
        5: chk("wrap_coilsB", coils, 10);
        6: begin chk("wrap_done", done, 1); chk("wrap_busy", busy, 0); chk("wrap_cnt", step_count, 2); end
        7: chk("wrap_done7", done, 0);
        default: ;
      endcase
    end
`endif

    $display("run: end marker base=10 len=5 period=2");
    start_run(13'd10, 14'd5, 1'b1, 24'd2);
    for (int k = 1; k <= 7; k++) begin
      tick();
      case (k)
        2: chk("mark_coils", coils, 3);
        4: chk("mark_addr4", mem_address, 11);
        5: chk("mark_done5", done, 0);
        6: begin chk("mark_done", done, 1); chk("mark_busy", busy, 0);
                 chk("mark_coils6", coils, 3); chk("mark_cnt", step_count, 1); end
        7: chk("mark_done7", done, 0);
        default: ;
      endcase
    end

    $display("run: abort during second hold");
    start_run(13'd100, 14'd4, 1'b1, 24'd3);
    repeat (7) tick();
    chk("abort_pre_coils", coils, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 1);
    chk("abort_coils", coils, 2);
    chk("abort_cnt", step_count, 2);
    tick();
    chk("abort_done_clr", done, 0);
    chk("abort_cs", mem_chipselect, 0);
    chk("abort_coils_hold", coils, 2);

    $display("run: length zero");
    start_run(13'd100, 14'd0, 1'b1, 24'd3);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_cs", mem_chipselect, 0);
    tick();
    chk("len0_done_clr", done, 0);
    chk("len0_cs1", mem_chipselect, 0);

    $display("run: start and stop together");
    stop = 1'b1;
    start_run(13'd100, 14'd4, 1'b1, 24'd3);
    stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_cs", mem_chipselect, 0);
    chk("ss_done", done, 0);
    tick();
    chk("ss_cs1", mem_chipselect, 0);

`ifdef MOTORPASSO_STEP_LOOP_EN
    $display("run: loop base=20 len=2 period=1");
    start_run(13'd20, 14'd2, 1'b1, 24'd1);
    chk("loop_addr0", mem_address, 20);
    chk("loop_cs0", mem_chipselect, 1);
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k % 3 == 0) begin
        chk("loop_cs", mem_chipselect, 1);
        chk("loop_addr", mem_address, ((k / 3) % 2 == 0) ? 20 : 21);
      end
      chk("loop_done", done, 0);
    end
    chk("loop_busy", busy, 1);
    chk("loop_cnt", step_count, 6);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("loop_stop_done", done, 1);
    chk("loop_stop_busy", busy, 0);
    tick();
    chk("loop_stop_done1", done, 0);
`endif

    $display("run: asynchronous reset mid-run");
    start_run(13'd100, 14'd4, 1'b1, 24'd3);
    repeat (12) tick();
    chk("arst_pre_coils", coils, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_coils", coils, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cs", mem_chipselect, 0);
    chk("arst_cnt", step_count, 0);
    tick();
    #2 reset_n = 1'b1;
    repeat (4) tick();
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_cs", mem_chipselect, 0);
    chk("arst_idle_coils", coils, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
